// File: rtl/prog_loader.sv
// Program loader: streams host bytes into the 256x8 RAM while holding the CPU,
// parsing opcodes on the fly for MOVI immediates, illegal opcodes and HALT.
module prog_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_abort,
  input  logic              i_in_valid,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_in_ready,
  output logic              o_ram_we,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic [DATA_W-1:0] o_ram_din,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_aborted,
  output logic [7:0]        o_checksum,
  output logic              o_bad_op,
  output logic              o_halt_seen
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_base, r_len, r_idx;
  logic              r_imm_next;
  logic              r_we, r_aborted, r_bad_op, r_halt_seen;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [7:0]        r_checksum;

  logic       w_hs, w_last, w_decode, w_is_movi, w_is_halt, w_is_bad;
  logic [3:0] w_opcode;

  // An abort in the same cycle blocks the handshake, so that byte is never written.
  assign o_in_ready = (r_state == S_LOAD) && !i_abort;
  assign w_hs       = o_in_ready && i_in_valid;
  assign w_last     = (r_idx == r_len - ADDR_W'(1));
  assign w_opcode   = i_in_data[DATA_W-1 -: 4];
  assign w_decode   = !r_imm_next;
  assign w_is_movi  = w_decode && (w_opcode == 4'hE);
  assign w_is_halt  = w_decode && (w_opcode == 4'hF);
  assign w_is_bad   = w_decode && (w_opcode[3:2] == 2'b00);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_next = (i_len == '0) ? S_DONE : S_LOAD;
      S_LOAD: begin
        if (i_abort)             w_next = S_IDLE;
        else if (w_hs && w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_imm_next  <= 1'b0;
      r_we        <= 1'b0;
      r_aborted   <= 1'b0;
      r_addr      <= '0;
      r_din       <= '0;
      r_checksum  <= '0;
      r_bad_op    <= 1'b0;
      r_halt_seen <= 1'b0;
    end else begin
      r_we      <= w_hs;
      r_aborted <= (r_state == S_LOAD) && i_abort;
      if (r_state == S_IDLE && i_start) begin
        r_base      <= i_base_addr;
        r_len       <= i_len;
        r_idx       <= '0;
        r_imm_next  <= 1'b0;
        r_checksum  <= '0;
        r_bad_op    <= 1'b0;
        r_halt_seen <= 1'b0;
      end
      if (w_hs) begin
        r_addr     <= r_base + r_idx;
        r_din      <= i_in_data;
        r_idx      <= r_idx + ADDR_W'(1);
        r_checksum <= r_checksum + 8'(i_in_data);
        r_imm_next <= w_is_movi;
        if (w_is_halt) r_halt_seen <= 1'b1;
        // A MOVI as the final byte has no immediate to follow it.
        if (w_is_bad || (w_is_movi && w_last)) r_bad_op <= 1'b1;
      end
    end
  end

  assign o_ram_we    = r_we;
  assign o_ram_addr  = r_addr;
  assign o_ram_din   = r_din;
  assign o_cpu_hold  = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_aborted   = r_aborted;
  assign o_checksum  = r_checksum;
  assign o_bad_op    = r_bad_op;
  assign o_halt_seen = r_halt_seen;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: sessions, parsing flags, wrap, abort, reset, len=0.
module tb_prog_loader;

  logic       clk, rst, start, abort, in_valid;
  logic [7:0] base_addr, len, in_data;
  logic       in_ready, ram_we, cpu_hold, done, aborted, bad_op, halt_seen;
  logic [7:0] ram_addr, ram_din, checksum;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int wr0, done0;

  prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_len(len), .i_abort(abort), .i_in_valid(in_valid), .i_in_data(in_data),
    .o_in_ready(in_ready), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_din(ram_din), .o_cpu_hold(cpu_hold), .o_done(done),
    .o_aborted(aborted), .o_checksum(checksum), .o_bad_op(bad_op),
    .o_halt_seen(halt_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_we) wr_cnt++;
    if (done)   done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_load(input logic [7:0] b, input logic [7:0] l);
    base_addr = b; len = l; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Present one byte with valid high; check the write registered on that edge.
  task automatic send(input string tag, input logic [7:0] d, input logic [7:0] a);
    in_valid = 1'b1; in_data = d;
    step();
    chk({tag, "_we"}, ram_we, 1'b1);
    chk({tag, "_addr"}, ram_addr, a);
    chk({tag, "_din"}, ram_din, d);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    base_addr = '0; len = '0; in_data = '0;
    step(); step();
    chk("rst_ready", in_ready, 0); chk("rst_we", ram_we, 0);
    chk("rst_hold", cpu_hold, 0);  chk("rst_done", done, 0);
    chk("rst_abt", aborted, 0);    chk("rst_cks", checksum, 0);
    chk("rst_bad", bad_op, 0);     chk("rst_halt", halt_seen, 0);
    rst = 1'b0;
    step();

    // Basic session, back-to-back bytes.
    begin_load(8'h10, 8'd3);
    chk("t1_hold", cpu_hold, 1); chk("t1_ready", in_ready, 1);
    send("t1_b0", 8'h48, 8'h10);
    chk("t1_b0_done", done, 0);
    send("t1_b1", 8'h9C, 8'h11);
    send("t1_b2", 8'hF0, 8'h12);
    in_valid = 1'b0;
    chk("t1_done", done, 1); chk("t1_rdy_done", in_ready, 0);
    chk("t1_cks", checksum, 8'hD4); chk("t1_halt", halt_seen, 1);
    chk("t1_bad", bad_op, 0); chk("t1_hold_done", cpu_hold, 1);
    step();
    chk("t1_hold_end", cpu_hold, 0); chk("t1_done_end", done, 0);
    chk("t1_we_end", ram_we, 0); chk("t1_cks_hold", checksum, 8'hD4);

    // MOVI immediate is skipped; following 0x2F is illegal.
    begin_load(8'h40, 8'd3);
    send("t2_b0", 8'hE0, 8'h40);
    send("t2_b1", 8'h05, 8'h41);
    send("t2_b2", 8'h2F, 8'h42);
    in_valid = 1'b0;
    chk("t2_done", done, 1); chk("t2_bad", bad_op, 1);
    chk("t2_halt", halt_seen, 0); chk("t2_cks", checksum, 8'h14);
    step();

    // 0xF3 is an immediate, not a HALT; start clears bad_op from the last session.
    begin_load(8'h50, 8'd2);
    chk("t3_bad_clr", bad_op, 0);
    send("t3_b0", 8'hE0, 8'h50);
    send("t3_b1", 8'hF3, 8'h51);
    in_valid = 1'b0;
    chk("t3_done", done, 1); chk("t3_halt", halt_seen, 0);
    chk("t3_bad", bad_op, 0); chk("t3_cks", checksum, 8'hD3);
    step();

    // Truncated MOVI at the end of the stream.
    begin_load(8'h60, 8'd2);
    send("t4_b0", 8'h40, 8'h60);
    send("t4_b1", 8'hE1, 8'h61);
    in_valid = 1'b0;
    chk("t4_done", done, 1); chk("t4_bad", bad_op, 1);
    chk("t4_halt", halt_seen, 0);
    step();

    // Address wrap with valid toggling.
    wr0 = wr_cnt;
    begin_load(8'hFE, 8'd4);
    chk("t5_hold", cpu_hold, 1);
    send("t5_b0", 8'h50, 8'hFE);
    in_valid = 1'b0; step();
    chk("t5_gap0_we", ram_we, 0); chk("t5_gap0_hold", cpu_hold, 1);
    send("t5_b1", 8'h60, 8'hFF);
    in_valid = 1'b0; step();
    chk("t5_gap1_we", ram_we, 0);
    send("t5_b2", 8'h70, 8'h00);
    in_valid = 1'b0; step();
    chk("t5_gap2_rdy", in_ready, 1);
    send("t5_b3", 8'h80, 8'h01);
    in_valid = 1'b0;
    chk("t5_done", done, 1); chk("t5_hold_done", cpu_hold, 1);
    chk("t5_cks", checksum, 8'hA0);
    step();
    chk("t5_hold_end", cpu_hold, 0);
    chk("t5_writes", wr_cnt - wr0, 4);

    // Abort after two of five bytes.
    wr0 = wr_cnt; done0 = done_cnt;
    begin_load(8'h20, 8'd5);
    send("t6_b0", 8'h21, 8'h20);
    send("t6_b1", 8'hF2, 8'h21);
    in_data = 8'h43; abort = 1'b1;
    #1;
    chk("t6_rdy_abort", in_ready, 0);
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("t6_aborted", aborted, 1); chk("t6_hold", cpu_hold, 0);
    chk("t6_we", ram_we, 0);
    chk("t6_bad", bad_op, 1); chk("t6_halt", halt_seen, 1);
    step();
    chk("t6_abt_pulse", aborted, 0);
    step();
    chk("t6_writes", wr_cnt - wr0, 2);
    chk("t6_no_done", done_cnt - done0, 0);

    // len == 0: immediate DONE, no writes, flags cleared by start.
    wr0 = wr_cnt;
    begin_load(8'h33, 8'd0);
    chk("t7_done", done, 1); chk("t7_we", ram_we, 0);
    chk("t7_rdy", in_ready, 0); chk("t7_bad", bad_op, 0);
    chk("t7_halt", halt_seen, 0); chk("t7_cks", checksum, 0);
    step();
    chk("t7_hold_end", cpu_hold, 0); chk("t7_done_end", done, 0);
    chk("t7_writes", wr_cnt - wr0, 0);

    // Reset during LOAD.
    begin_load(8'h80, 8'd4);
    send("t8_b0", 8'hF0, 8'h80);
    #1 rst = 1'b1;
    #1;
    chk("t8_rdy", in_ready, 0); chk("t8_we", ram_we, 0);
    chk("t8_hold", cpu_hold, 0); chk("t8_addr", ram_addr, 0);
    chk("t8_din", ram_din, 0); chk("t8_cks", checksum, 0);
    chk("t8_halt", halt_seen, 0);
    wr0 = wr_cnt;
    step();
    rst = 1'b0; in_data = 8'h41;
    step(); step(); step();
    in_valid = 1'b0;
    chk("t8_no_wr", wr_cnt - wr0, 0);
    chk("t8_we_after", ram_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
